// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// FSM state encoding, memory geometry and small helper functions.
package imem_loader_pkg;

    localparam int   IMEM_ADDR_W        = 6;
    localparam int   IMEM_WORDS         = 64;
    localparam logic LEN_ZERO_MEANS_MAX = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Running stream checksum: plain XOR of every byte folded in.
    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

    // Map the length byte to a word count. Zero selects the full memory;
    // anything larger than the memory is clamped so a load can never wrap.
    function automatic logic [6:0] len_to_words(input logic [7:0] len, input logic [6:0] max_words);
        logic [6:0] n;
        if (len == 8'd0) begin
            n = LEN_ZERO_MEANS_MAX ? max_words : 7'd0;
        end else if (len > {1'b0, max_words}) begin
            n = max_words;
        end else begin
            n = len[6:0];
        end
        return n;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = stream source / memory side, slave = the loader itself.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs stream bytes MSB-first into 32-bit words and keeps the running
// XOR checksum. Only the three older bytes are stored: the newest byte
// is combined on the fly so the completed word is available in the same
// cycle as its last byte.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic [7:0]  init_chk,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full,
    output logic [7:0]  chk
);

    logic [23:0] shift_r;
    logic [1:0]  byte_idx_r;
    logic [7:0]  chk_r;

    assign word_next = {shift_r, byte_in};
    assign word_full = (byte_idx_r == 2'd3);
    assign chk       = chk_r;

    // Shift register, byte position and checksum; init seeds the checksum with L.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r    <= 24'd0;
            byte_idx_r <= 2'd0;
            chk_r      <= 8'd0;
        end else if (init) begin
            shift_r    <= 24'd0;
            byte_idx_r <= 2'd0;
            chk_r      <= init_chk;
        end else if (push) begin
            shift_r    <= word_next[23:0];
            byte_idx_r <= byte_idx_r + 2'd1;
            chk_r      <= chk_update(chk_r, byte_in);
        end else begin
            shift_r    <= shift_r;
            byte_idx_r <= byte_idx_r;
            chk_r      <= chk_r;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Synthesizable program-load path for the instruction memory: accepts
// a length-prefixed, checksummed byte stream, writes the packed words
// from address 0 upward and holds the CPU until the load has finished.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int WORDS  = IMEM_WORDS
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [6:0] N_MAX_C = 7'(WORDS);

    state_e            state_r;
    state_e            next_state_s;
    logic              in_ready_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              hold_r;
    logic              done_r;
    logic              err_r;
    logic [6:0]        n_words_r;
    logic [6:0]        word_cnt_r;
    logic [ADDR_W-1:0] addr_r;

    logic              xfer_s;
    logic              len_xfer_s;
    logic              data_xfer_s;
    logic              word_full_s;
    logic [31:0]       word_next_s;
    logic [7:0]        chk_s;

    // in_ready is a registered decode of the state, so it is safe to gate the transfer with it.
    assign xfer_s      = bus.in_valid & in_ready_r;
    assign len_xfer_s  = xfer_s & (state_r == ST_LEN);
    assign data_xfer_s = xfer_s & (state_r == ST_DATA);

    assign bus.in_ready  = in_ready_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign cpu_hold      = hold_r;
    assign busy          = hold_r;
    assign done          = done_r;
    assign err           = err_r;

    word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .init      (len_xfer_s),
        .init_chk  (bus.in_data),
        .push      (data_xfer_s),
        .byte_in   (bus.in_data),
        .word_next (word_next_s),
        .word_full (word_full_s),
        .chk       (chk_s)
    );

    // Next-state decode for the load sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_LEN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (xfer_s) begin
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_LEN;
                end
            end
            ST_DATA: begin
                if (xfer_s && word_full_s) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                if ((word_cnt_r + 7'd1) == n_words_r) begin
                    next_state_s = ST_CHK;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_CHK: begin
                if (xfer_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CHK;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register and the flag outputs, all registered off the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            hold_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s == ST_LEN) || (next_state_s == ST_DATA) ||
                          (next_state_s == ST_CHK);
            mem_we_r   <= (next_state_s == ST_WRITE);
            hold_r     <= (next_state_s != ST_IDLE);
            done_r     <= (next_state_s == ST_DONE);
        end
    end

    // Word count, write address and memory write data/address capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_words_r   <= 7'd0;
            word_cnt_r  <= 7'd0;
            addr_r      <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
        end else begin
            if (len_xfer_s) begin
                n_words_r  <= len_to_words(bus.in_data, N_MAX_C);
                word_cnt_r <= 7'd0;
                addr_r     <= '0;
            end else if (state_r == ST_WRITE) begin
                n_words_r  <= n_words_r;
                word_cnt_r <= word_cnt_r + 7'd1;
                addr_r     <= addr_r + 1'b1;
            end else begin
                n_words_r  <= n_words_r;
                word_cnt_r <= word_cnt_r;
                addr_r     <= addr_r;
            end
            // Address/data are latched with the last byte and held between strobes.
            if (data_xfer_s && word_full_s) begin
                mem_addr_r  <= addr_r;
                mem_wdata_r <= word_next_s;
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Checksum verdict: cleared by a new start, set by the trailing checksum byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_CHK) && xfer_s) begin
            err_r <= (bus.in_data != chk_s);
        end else begin
            err_r <= err_r;
        end
    end

endmodule
